// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address-width helper, used by every pipeline stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; at least one bit so a
    // degenerate count still yields a legal vector.
    function automatic int calc_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reserve, cleared by write.
// Latency: busy_o updates one edge after the reserve/write.
// Backpressure: none; decode stalls on the busy bits itself.
//
// Ports: clk_i/rst_ni clock and async active-low reset; rsv_i/rsv_addr_i
// reserve request; wen_i/waddr_i write-port enables and addresses;
// busy_o registered scoreboard vector.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             rsv_i,
    input  logic [calc_aw(NREGS)-1:0]        rsv_addr_i,
    input  logic [NWR-1:0]                   wen_i,
    input  logic [NWR*calc_aw(NREGS)-1:0]    waddr_i,
    output logic [NREGS-1:0]                 busy_o
);

    localparam int AW = calc_aw(NREGS);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_clr = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wen_i[j]) begin
                w_clr[waddr_i[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // A reserve outranks a same-edge write: the reservation belongs to a
    // younger instruction whose result is still outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (rsv_i && (rsv_addr_i == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (w_clr[i]) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and pending-write scoreboard.
// Latency: reads combinational (0), writes visible next cycle (1), busy_o one edge after reserve/write.
// Backpressure: none; never stalls, decode stalls on rbusy_o.
//
// Ports: raddr_i/rdata_o/rbusy_o NRD read ports (slice k = port k);
// wen_i/waddr_i/wdata_i NWR write ports, highest index wins on collision;
// rsv_i/rsv_addr_i reserve request; busy_o full registered busy vector.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NRD*calc_aw(NREGS)-1:0]    raddr_i,
    output logic [NRD*XLEN-1:0]              rdata_o,
    output logic [NRD-1:0]                   rbusy_o,
    input  logic [NWR-1:0]                   wen_i,
    input  logic [NWR*calc_aw(NREGS)-1:0]    waddr_i,
    input  logic [NWR*XLEN-1:0]              wdata_i,
    input  logic                             rsv_i,
    input  logic [calc_aw(NREGS)-1:0]        rsv_addr_i,
    output logic [NREGS-1:0]                 busy_o
);

    localparam int AW = calc_aw(NREGS);

    logic [XLEN-1:0]  w_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Storage. Register 0 has no flops when hardwired to zero.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_flop
            logic [XLEN-1:0] r_data;
            // Later ports overwrite earlier ones, so port NWR-1 wins a collision.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_data <= '0;
                end else begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wen_i[j] && (waddr_i[j*AW +: AW] == AW'(i))) begin
                            r_data <= wdata_i[j*XLEN +: XLEN];
                        end
                    end
                end
            end
            assign w_regs[i] = r_data;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rsv_i      (rsv_i),
        .rsv_addr_i (rsv_addr_i),
        .wen_i      (wen_i),
        .waddr_i    (waddr_i),
        .busy_o     (w_busy)
    );

    assign busy_o = w_busy;

    // Read ports with same-cycle bypass.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_hit;
        logic [XLEN-1:0] w_byp;
        logic            w_zero;
        logic            w_rsv_hit;
        logic            w_use_byp;

        assign w_ra = raddr_i[k*AW +: AW];

        // Highest-index matching write port supplies the bypass data.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wen_i[j] && (waddr_i[j*AW +: AW] == w_ra)) begin
                    w_hit = 1'b1;
                    w_byp = wdata_i[j*XLEN +: XLEN];
                end
            end
        end

        assign w_zero    = (ZERO_REG != 0) && (w_ra == '0);
        assign w_rsv_hit = rsv_i && (rsv_addr_i == w_ra);
        // Bypass is suppressed during reset so reads are 0 while reset is held.
        assign w_use_byp = (BYPASS != 0) && rst_ni && w_hit && !w_zero;

        assign rdata_o[k*XLEN +: XLEN] = w_use_byp ? w_byp : w_regs[w_ra];
        // An arriving write retires the pending value unless a new reserve
        // re-claims the same register on this edge.
        assign rbusy_o[k] = (w_use_byp && !w_rsv_hit) ? 1'b0 : w_busy[w_ra];
    end

endmodule
